// File: rtl/pc_flow_unit.sv
// Program-flow unit: program counter, call/return stack with overflow and
// underflow flags, stall, conditional jump and one vectored interrupt.
module pc_flow_unit #(
  parameter int MINSTW = 9,
  parameter int SDEPTH = 8,
  parameter int RSTADR = 0,
  parameter int IRQVEC = 1,
  parameter int IRQ_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         jmp,
  input  logic                         jz,
  input  logic                         cond,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         reti,
  input  logic [MINSTW-1:0]            target,
  input  logic                         irq,
  input  logic                         clr_err,
  output logic [MINSTW-1:0]            instr_addr,
  output logic [MINSTW-1:0]            pc,
  output logic                         instr_vld,
  output logic                         irq_ack,
  output logic                         in_isr,
  output logic [$clog2(SDEPTH+1)-1:0]  stk_lvl,
  output logic                         stk_ovf,
  output logic                         stk_unf
);
  localparam int LW = $clog2(SDEPTH + 1);
  localparam int IW = $clog2(SDEPTH);

  typedef enum logic [1:0] {BOOT, RUN, ISR} state_t;

  state_t            r_state, w_state_nx;
  logic [MINSTW-1:0] r_pc, w_npc, w_pc1;
  logic [MINSTW-1:0] r_stk [SDEPTH];
  logic [LW-1:0]     r_lvl, w_lvl_nx, w_lvl_m1;
  logic [IW-1:0]     w_wr_idx, w_rd_idx;
  logic              r_ovf, r_unf;
  logic              w_ovf_evt, w_unf_evt, w_push;
  logic              w_full, w_empty, w_any_ctl, w_irq_take;

  assign w_pc1     = r_pc + MINSTW'(1);
  assign w_lvl_m1  = r_lvl - LW'(1);
  assign w_wr_idx  = r_lvl[IW-1:0];
  assign w_rd_idx  = w_lvl_m1[IW-1:0];
  assign w_full    = (r_lvl == LW'(SDEPTH));
  assign w_empty   = (r_lvl == '0);
  assign w_any_ctl = jmp | jz | call | ret | reti;
  // Interrupt only slips into a plain sequential cycle; the source must hold irq.
  assign w_irq_take = (IRQ_EN != 0) && (r_state == RUN) && irq && !stall && !w_any_ctl;

  always_comb begin
    w_npc      = r_pc;
    w_state_nx = r_state;
    w_lvl_nx   = r_lvl;
    w_push     = 1'b0;
    w_ovf_evt  = 1'b0;
    w_unf_evt  = 1'b0;
    if (r_state == BOOT) begin
      w_npc = MINSTW'(RSTADR);
      if (!stall) w_state_nx = RUN;
    end else if (!stall) begin
      if (w_irq_take) begin
        w_npc      = MINSTW'(IRQVEC);
        w_push     = 1'b1;
        w_state_nx = ISR;
      end else if (ret || reti) begin
        if (w_empty) begin
          w_npc     = w_pc1;
          w_unf_evt = 1'b1;
        end else begin
          w_npc    = r_stk[w_rd_idx];
          w_lvl_nx = w_lvl_m1;
        end
        if (reti && r_state == ISR) w_state_nx = RUN;
      end else if (call) begin
        w_npc  = target;
        w_push = 1'b1;
      end else if (jmp) begin
        w_npc = target;
      end else if (jz && !cond) begin
        w_npc = target;
      end else begin
        w_npc = w_pc1;
      end
      // A push on a full stack still jumps; only the write is dropped.
      if (w_push) begin
        if (w_full) w_ovf_evt = 1'b1;
        else        w_lvl_nx  = r_lvl + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BOOT;
      r_pc    <= MINSTW'(RSTADR);
      r_lvl   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_npc;
      r_lvl   <= w_lvl_nx;
      if (!stall) begin
        r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
        r_unf <= w_unf_evt | (r_unf & ~clr_err);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_full) r_stk[w_wr_idx] <= w_pc1;
  end

  assign instr_addr = w_npc;
  assign pc         = r_pc;
  assign instr_vld  = (r_state != BOOT) && !stall;
  assign irq_ack    = w_irq_take;
  assign in_isr     = (IRQ_EN != 0) && (r_state == ISR);
  assign stk_lvl    = r_lvl;
  assign stk_ovf    = r_ovf;
  assign stk_unf    = r_unf;
endmodule

// File: tb/tb_pc_flow_unit.sv
// Scoreboard bench for pc_flow_unit: directed cycles push expected outputs,
// a negedge monitor pops and compares them.
module tb_pc_flow_unit;
  logic       clk = 1'b0;
  logic       rst, stall, jmp, jz, cond, call, ret, reti, irq, clr_err;
  logic [8:0] target;
  logic [8:0] instr_addr, pc;
  logic       instr_vld, irq_ack, in_isr, stk_ovf, stk_unf;
  logic [3:0] stk_lvl;

  typedef struct {
    string      nm;
    logic [8:0] ia, pc;
    logic       vld, ack, isr;
    logic [3:0] lvl;
    logic       ovf, unf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  pc_flow_unit #(.MINSTW(9), .SDEPTH(8), .RSTADR(0), .IRQVEC(1), .IRQ_EN(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jmp(jmp), .jz(jz), .cond(cond),
    .call(call), .ret(ret), .reti(reti), .target(target), .irq(irq),
    .clr_err(clr_err), .instr_addr(instr_addr), .pc(pc), .instr_vld(instr_vld),
    .irq_ack(irq_ack), .in_isr(in_isr), .stk_lvl(stk_lvl), .stk_ovf(stk_ovf),
    .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got=%0h exp=%0h", nm, f, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, "instr_addr", 32'(instr_addr), 32'(e.ia));
      chk(e.nm, "pc",         32'(pc),         32'(e.pc));
      chk(e.nm, "instr_vld",  32'(instr_vld),  32'(e.vld));
      chk(e.nm, "irq_ack",    32'(irq_ack),    32'(e.ack));
      chk(e.nm, "in_isr",     32'(in_isr),     32'(e.isr));
      chk(e.nm, "stk_lvl",    32'(stk_lvl),    32'(e.lvl));
      chk(e.nm, "stk_ovf",    32'(stk_ovf),    32'(e.ovf));
      chk(e.nm, "stk_unf",    32'(stk_unf),    32'(e.unf));
    end
  end

  task automatic clr();
    stall = 0; jmp = 0; jz = 0; cond = 0; call = 0; ret = 0; reti = 0;
    clr_err = 0; target = '0;
  endtask

  task automatic cyc(input string nm, input logic [8:0] ia, input logic [8:0] p,
                     input logic vld, input logic ack, input logic isr,
                     input logic [3:0] lvl, input logic ovf, input logic unf);
    exp_t e;
    e.nm = nm; e.ia = ia; e.pc = p; e.vld = vld; e.ack = ack; e.isr = isr;
    e.lvl = lvl; e.ovf = ovf; e.unf = unf;
    q.push_back(e);
    @(posedge clk); #1;
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    rst = 0; irq = 0; clr();
    @(posedge clk); #1;
    cyc("reset", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0);
    rst = 1;
    cyc("boot", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("seq", 9'(i + 1), 9'(i), 1, 0, 0, 0, 0, 0);
    call = 1; target = 9'h040;
    cyc("call", 9'h040, 9'h005, 1, 0, 0, 0, 0, 0);
    cyc("callee", 9'h041, 9'h040, 1, 0, 0, 1, 0, 0);
    ret = 1;
    cyc("ret", 9'h006, 9'h041, 1, 0, 0, 1, 0, 0);
    // nine nested calls on an 8-deep stack: the 9th jumps but overflows
    for (int k = 0; k < 9; k++) begin
      call = 1; target = 9'h050;
      cyc("nest", 9'h050, (k == 0) ? 9'h006 : 9'h050, 1, 0, 0, 4'(k), 0, 0);
    end
    for (int j = 0; j < 8; j++) begin
      ret = 1;
      cyc("unwind", (j == 7) ? 9'h007 : 9'h051, (j == 0) ? 9'h050 : 9'h051,
          1, 0, 0, 4'(8 - j), 1, 0);
    end
    jmp = 1; target = 9'h010;
    cyc("jmp", 9'h010, 9'h007, 1, 0, 0, 0, 1, 0);
    ret = 1;
    cyc("ret empty", 9'h011, 9'h010, 1, 0, 0, 0, 1, 0);
    clr_err = 1;
    cyc("clr", 9'h012, 9'h011, 1, 0, 0, 0, 1, 1);
    ret = 1; clr_err = 1;
    cyc("set wins", 9'h013, 9'h012, 1, 0, 0, 0, 0, 0);
    clr_err = 1;
    cyc("clr2", 9'h014, 9'h013, 1, 0, 0, 0, 0, 1);
    jmp = 1; target = 9'h003;
    cyc("jmp3", 9'h003, 9'h014, 1, 0, 0, 0, 0, 0);
    irq = 1; jmp = 1; target = 9'h020;
    cyc("irq defer", 9'h020, 9'h003, 1, 0, 0, 0, 0, 0);
    cyc("irq take", 9'h001, 9'h020, 1, 1, 0, 0, 0, 0);
    cyc("isr", 9'h002, 9'h001, 1, 0, 1, 1, 0, 0);
    cyc("isr masked", 9'h003, 9'h002, 1, 0, 1, 1, 0, 0);
    reti = 1;
    cyc("reti", 9'h021, 9'h003, 1, 0, 1, 1, 0, 0);
    irq = 0; jz = 1; cond = 1; target = 9'h030;
    cyc("jz not taken", 9'h022, 9'h021, 1, 0, 0, 0, 0, 0);
    jz = 1; cond = 0; target = 9'h030;
    cyc("jz taken", 9'h030, 9'h022, 1, 0, 0, 0, 0, 0);
    cyc("plain", 9'h031, 9'h030, 1, 0, 0, 0, 0, 0);
    jmp = 1; target = 9'h1FF;
    cyc("jmp top", 9'h1FF, 9'h031, 1, 0, 0, 0, 0, 0);
    cyc("wrap", 9'h000, 9'h1FF, 1, 0, 0, 0, 0, 0);
    cyc("pc0", 9'h001, 9'h000, 1, 0, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      stall = 1; call = 1; target = 9'h060;
      cyc("stall", 9'h001, 9'h001, 0, 0, 0, 0, 0, 0);
    end
    call = 1; target = 9'h060;
    cyc("call after stall", 9'h060, 9'h001, 1, 0, 0, 0, 0, 0);
    irq = 1;
    cyc("irq2 take", 9'h001, 9'h060, 1, 1, 0, 1, 0, 0);
    irq = 0;
    cyc("in isr2", 9'h002, 9'h001, 1, 0, 1, 2, 0, 0);
    rst = 0;
    cyc("rst mid isr", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0);
    rst = 1;
    cyc("boot2", 9'h000, 9'h000, 0, 0, 0, 0, 0, 0);
    cyc("run2", 9'h001, 9'h000, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("drain", "queue", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_flow_unit.md
Name: pc_flow_unit

Overview:
- Parametrised program-flow unit for the multicore fixed-point processor.
- Holds the program counter and a call/return stack of configurable depth, with overflow and underflow detection.
- Adds stall, a conditional jump, and one vectored interrupt with return-from-interrupt.
- Drives the address of a synchronous-read instruction memory and receives decoded flow controls from the instruction decoder.

Parameters:
- MINSTW, 9: instruction address width.
- SDEPTH, 8: call stack entries, must be 2 or more.
- RSTADR, 0: first fetch address after reset.
- IRQVEC, 1: interrupt vector address.
- IRQ_EN, 1: 0 removes the interrupt logic; irq is ignored and irq_ack and in_isr are tied to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- stall  in  1  freeze PC, stack and FSM.
- jmp  in  1  unconditional jump to target.
- jz  in  1  jump to target if cond==0.
- cond  in  1  condition bit (accumulator LSB).
- call  in  1  push return address, jump to target.
- ret  in  1  pop, jump to popped address.
- reti  in  1  like ret, also leaves ISR.
- target  in  MINSTW  jump/call destination.
- irq  in  1  level interrupt request.
- clr_err  in  1  clears sticky flags.
- instr_addr  out  MINSTW  address presented to instruction memory (combinational next-PC).
- pc  out  MINSTW  address of the instruction currently decoded.
- instr_vld  out  1  the current memory output is a valid instruction.
- irq_ack  out  1  one-cycle pulse when the interrupt is taken.
- in_isr  out  1  executing the handler.
- stk_lvl  out  $clog2(SDEPTH+1)  number of stack entries.
- stk_ovf  out  1  sticky push-when-full.
- stk_unf  out  1  sticky pop-when-empty.

Behaviour:
- **Reset** (rst==0, async):
  - State BOOT; pc=RSTADR, instr_addr=RSTADR.
  - instr_vld=0, irq_ack=0, in_isr=0, stk_lvl=0, both flags 0.
  - Stack contents are don't-care.
- **FSM states**: BOOT, RUN, ISR.
  - BOOT: instr_addr=RSTADR, instr_vld=0; next cycle goes to RUN with pc=RSTADR.
  - RUN and ISR: instr_vld=1 except when stall=1.
- **Next-PC (npc) priority**, evaluated only when not stalled. Decoder asserts at most one control; if several are asserted, this order decides:
  1. interrupt take
  2. reti / ret
  3. call
  4. jmp
  5. jz with cond==0
  6. pc+1
- **Register update**: instr_addr=npc; pc<=npc at the clock edge. pc+1 wraps modulo 2^MINSTW, so 2^MINSTW-1 goes to 0.
- **call**:
  - Writes pc+1 at index stk_lvl, stk_lvl+1, npc=target.
  - If stk_lvl==SDEPTH: no write, level unchanged, stk_ovf<=1, jump still taken.
- **ret / reti**:
  - npc = entry at stk_lvl-1, stk_lvl-1.
  - If stk_lvl==0: npc=pc+1, stk_unf<=1.
  - reti in ISR: ISR->RUN, in_isr<=0. reti in RUN behaves as ret.
- **Interrupt take**:
  - Requires state RUN, irq=1, IRQ_EN=1, stall=0, and no flow control asserted that cycle. Otherwise the interrupt is deferred; irq must be held.
  - Pushes pc+1 with the same overflow rule as call.
  - npc=IRQVEC; RUN->ISR; in_isr<=1; irq_ack=1 for exactly that cycle.
  - irq is masked in ISR (no nesting). call/ret work normally inside ISR.
- **stall=1**:
  - instr_addr=pc (refetch); pc, stack, level, FSM and flags hold.
  - instr_vld=0, irq_ack=0.
  - stall in BOOT delays the move to RUN.
- **clr_err=1**: clears both flags next edge. If an error event happens in the same cycle, setting wins.
- **Latency**: a jump, call or return is visible on instr_addr in the same cycle as the control; the target instruction is decoded (pc==target) on the next cycle.

Test Plan:
- Reset release with no controls -> BOOT one cycle with instr_addr=0, instr_vld=0; then pc=0,1,2,3 with instr_vld=1.
- call target=0x40 at pc=5, then ret at pc=0x41 -> instr_addr=0x40 (stk_lvl=1), then 0x06 (stk_lvl=0); stk_ovf=0, stk_unf=0.
- SDEPTH=8: 9 nested calls -> stk_ovf=1 at the 9th while it still jumps, stk_lvl stays 8. Ret on empty stack at pc=0x10 -> instr_addr=0x11, stk_unf=1. clr_err -> both flags 0.
- irq=1 during jmp at pc=3 -> jump taken, irq deferred. Next plain cycle at pc=0x20 -> irq_ack pulse, instr_addr=1, in_isr=1. irq kept high -> no second ack. reti -> instr_addr=0x21, in_isr=0.
- jz target=0x30 with cond=1 -> pc+1; with cond=0 -> 0x30. MINSTW=9 at pc=0x1FF with no control -> wraps to 0x000.
- stall held 3 cycles during a call -> instr_addr=pc, stk_lvl unchanged, instr_vld=0. rst driven low mid-ISR -> immediately in_isr=0, stk_lvl=0, instr_addr=RSTADR.
